// File: rtl/sap_memory_unit_if.sv
// Bus, CPU memory-control and program-loader signals of the SAP memory unit.
// master = control block / loader side, slave = memory unit.
interface sap_memory_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              mar_addr_load_n;
  logic              mar_mem_load_n;
  logic              ram_en_n;
  logic              ram_load_n;
  logic [ADDR_W-1:0] mar_out;
  logic              prog_mode;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic [ADDR_W:0]   prog_count;
  logic              prog_done;
  logic              conflict_err;

  modport master (
    output bus_in, mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n,
           prog_mode, prog_valid, prog_data,
    input  bus_out, bus_oe, mar_out, prog_ready, prog_count, prog_done,
           conflict_err
  );

  modport slave (
    input  bus_in, mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n,
           prog_mode, prog_valid, prog_data,
    output bus_out, bus_oe, mar_out, prog_ready, prog_count, prog_done,
           conflict_err
  );
endinterface

// File: rtl/sap_memory_unit.sv
// SAP memory unit: memory address register plus DEPTH x DATA_W RAM on the
// shared bus, with a byte-serial valid/ready program loader.
module sap_memory_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sap_memory_unit_if.slave     bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [DATA_W-1:0] ram_d [DEPTH];
  logic [ADDR_W:0]   prog_count_q, prog_count_d;
  logic              conflict_q, conflict_d;

  logic              cpu_active;
  logic              cpu_read;
  logic              cpu_write;
  logic              prog_accept;
  logic [DATA_W-1:0] rd_data;

  // CPU control decode; prog_mode masks every CPU control input
  always_comb begin
    cpu_active  = !bus.prog_mode;
    rd_data     = ram_q[mar_q];
    cpu_read    = cpu_active && !bus.ram_en_n;
    // a simultaneous read suppresses the write
    cpu_write   = cpu_active && !bus.ram_load_n && bus.ram_en_n;
    prog_accept = (state_q == ST_LOAD) && bus.prog_mode && bus.prog_valid;
  end

  // Loader FSM next state and byte counter
  always_comb begin
    state_d      = state_q;
    prog_count_d = prog_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.prog_mode) begin
          state_d      = ST_LOAD;
          prog_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (!bus.prog_mode) begin
          state_d = ST_IDLE;
        end else if (prog_accept) begin
          prog_count_d = prog_count_q + (ADDR_W+1)'(1);
          if (prog_count_q == (ADDR_W+1)'(DEPTH - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.prog_mode) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM write port: loader and CPU writes are mutually exclusive via prog_mode
  always_comb begin
    ram_d = ram_q;
    if (prog_accept) begin
      ram_d[prog_count_q[ADDR_W-1:0]] = bus.prog_data;
    end else if (cpu_write) begin
      ram_d[mar_q] = bus.bus_in;
    end
  end

  // MAR update and sticky read/write conflict flag
  always_comb begin
    mar_d      = mar_q;
    conflict_d = conflict_q;
    // leaving the loader (FSM not idle, prog_mode dropped) restarts execution at 0
    if (state_q != ST_IDLE && !bus.prog_mode) begin
      mar_d = '0;
    end else if (cpu_active) begin
      if (!bus.mar_addr_load_n)     mar_d = bus.bus_in[ADDR_W-1:0];
      else if (!bus.mar_mem_load_n) mar_d = rd_data[ADDR_W-1:0];
    end
    if (cpu_active && !bus.ram_en_n && !bus.ram_load_n) conflict_d = 1'b1;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mar_q        <= '0;
      prog_count_q <= '0;
      conflict_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      mar_q        <= mar_d;
      prog_count_q <= prog_count_d;
      conflict_q   <= conflict_d;
      ram_q        <= ram_d;
    end
  end

  assign bus.bus_oe       = cpu_read;
  assign bus.bus_out      = cpu_read ? rd_data : '0;
  assign bus.mar_out      = mar_q;
  assign bus.prog_ready   = (state_q == ST_LOAD) && bus.prog_mode;
  assign bus.prog_count   = prog_count_q;
  assign bus.prog_done    = (state_q == ST_DONE);
  assign bus.conflict_err = conflict_q;
endmodule

// File: tb/tb_sap_memory_unit.sv
// Directed self-checking bench for sap_memory_unit.
module tb_sap_memory_unit;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  sap_memory_unit_if #(.ADDR_W(4), .DATA_W(8)) bif ();

  sap_memory_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    bif.mar_addr_load_n = 1'b1;
    bif.mar_mem_load_n  = 1'b1;
    bif.ram_en_n        = 1'b1;
    bif.ram_load_n      = 1'b1;
    bif.bus_in          = 8'h00;
  endtask

  task automatic set_mar(input logic [7:0] v);
    cpu_idle();
    bif.bus_in          = v;
    bif.mar_addr_load_n = 1'b0;
    tick();
    cpu_idle();
  endtask

  task automatic write_byte(input logic [7:0] v);
    cpu_idle();
    bif.bus_in     = v;
    bif.ram_load_n = 1'b0;
    tick();
    cpu_idle();
  endtask

  // Sets MAR to addr and samples the combinational read in the \CE cycle
  task automatic read_addr(input logic [3:0] addr, output logic [7:0] data,
                           output logic oe);
    set_mar({4'h0, addr});
    bif.ram_en_n = 1'b0;
    #1;
    data = bif.bus_out;
    oe   = bif.bus_oe;
    tick();
    cpu_idle();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       oe;
    // build nonzero state first
    set_mar(8'h0A);
    write_byte(8'hFF);
    bif.ram_en_n   = 1'b0;
    bif.ram_load_n = 1'b0;
    tick();
    cpu_idle();
    n_vec++;
    if (bif.conflict_err !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_conflict got=%b exp=1", bif.conflict_err);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if (bif.mar_out !== 4'h0 || bif.bus_oe !== 1'b0 || bif.bus_out !== 8'h00 ||
        bif.prog_count !== 5'd0 || bif.prog_done !== 1'b0 ||
        bif.conflict_err !== 1'b0 || bif.prog_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got mar=%h oe=%b out=%h cnt=%0d done=%b cerr=%b rdy=%b exp all 0",
               bif.mar_out, bif.bus_oe, bif.bus_out, bif.prog_count,
               bif.prog_done, bif.conflict_err, bif.prog_ready);
    end
    for (int i = 0; i < 16; i++) begin
      read_addr(4'(i), d, oe);
      n_vec++;
      if (d !== 8'h00 || oe !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ram[%0d] got=%h oe=%b exp=00 oe=1", i, d, oe);
      end
    end
  endtask

  task automatic test_load();
    int         b;
    logic [7:0] d;
    logic       oe;
    bif.prog_mode = 1'b1;
    tick();
    b = 0;
    for (int cyc = 0; cyc < 40 && b < 16; cyc++) begin
      bif.prog_valid = !(cyc == 3 || cyc == 8 || cyc == 12);
      bif.prog_data  = 8'h10 + 8'(b);
      #1;
      n_vec++;
      if (bif.prog_count !== 5'(b) || bif.prog_ready !== 1'b1 || bif.bus_oe !== 1'b0) begin
        n_err++;
        $display("FAIL load_step cyc=%0d got cnt=%0d rdy=%b oe=%b exp cnt=%0d rdy=1 oe=0",
                 cyc, bif.prog_count, bif.prog_ready, bif.bus_oe, b);
      end
      tick();
      if (bif.prog_valid) b++;
    end
    bif.prog_valid = 1'b0;
    n_vec++;
    if (b != 16) begin
      n_err++;
      $display("FAIL load_timeout got bytes=%0d exp=16", b);
    end
    n_vec++;
    if (bif.prog_done !== 1'b1 || bif.prog_ready !== 1'b0 || bif.prog_count !== 5'd16) begin
      n_err++;
      $display("FAIL load_done got done=%b rdy=%b cnt=%0d exp done=1 rdy=0 cnt=16",
               bif.prog_done, bif.prog_ready, bif.prog_count);
    end
    // extra byte in DONE is ignored
    bif.prog_valid = 1'b1;
    bif.prog_data  = 8'hEE;
    tick();
    bif.prog_valid = 1'b0;
    n_vec++;
    if (bif.prog_count !== 5'd16 || bif.prog_done !== 1'b1) begin
      n_err++;
      $display("FAIL done_extra got cnt=%0d done=%b exp cnt=16 done=1",
               bif.prog_count, bif.prog_done);
    end
    bif.prog_mode = 1'b0;
    tick();
    n_vec++;
    if (bif.mar_out !== 4'h0 || bif.prog_done !== 1'b0 || bif.prog_count !== 5'd16) begin
      n_err++;
      $display("FAIL load_exit got mar=%h done=%b cnt=%0d exp mar=0 done=0 cnt=16",
               bif.mar_out, bif.prog_done, bif.prog_count);
    end
    read_addr(4'd5, d, oe);
    n_vec++;
    if (d !== 8'h15) begin
      n_err++;
      $display("FAIL load_rd5 got=%h exp=15", d);
    end
    read_addr(4'd0, d, oe);
    n_vec++;
    if (d !== 8'h10) begin
      n_err++;
      $display("FAIL load_rd0 got=%h exp=10", d);
    end
  endtask

  task automatic test_cpu_rw();
    set_mar(8'hA7);
    n_vec++;
    if (bif.mar_out !== 4'h7) begin
      n_err++;
      $display("FAIL lma_trunc got=%h exp=7", bif.mar_out);
    end
    write_byte(8'h3C);
    #1;
    n_vec++;
    if (bif.bus_oe !== 1'b0 || bif.bus_out !== 8'h00) begin
      n_err++;
      $display("FAIL idle_bus got oe=%b out=%h exp oe=0 out=00", bif.bus_oe, bif.bus_out);
    end
    bif.ram_en_n = 1'b0;
    #1;
    n_vec++;
    if (bif.bus_oe !== 1'b1 || bif.bus_out !== 8'h3C) begin
      n_err++;
      $display("FAIL ce_read got oe=%b out=%h exp oe=1 out=3c", bif.bus_oe, bif.bus_out);
    end
    tick();
    cpu_idle();
  endtask

  task automatic test_mem_load();
    logic [7:0] d;
    logic       oe;
    set_mar(8'h02);
    write_byte(8'h49);
    bif.mar_mem_load_n = 1'b0;
    tick();
    cpu_idle();
    n_vec++;
    if (bif.mar_out !== 4'h9) begin
      n_err++;
      $display("FAIL lmd got=%h exp=9", bif.mar_out);
    end
    // ram[9]=0x19 from the loader, so \L_MD alone would give 9
    bif.bus_in          = 8'h04;
    bif.mar_addr_load_n = 1'b0;
    bif.mar_mem_load_n  = 1'b0;
    tick();
    cpu_idle();
    n_vec++;
    if (bif.mar_out !== 4'h4) begin
      n_err++;
      $display("FAIL lma_wins got=%h exp=4", bif.mar_out);
    end
    // MAR load and write together: write goes to old MAR (4)
    bif.bus_in          = 8'h0B;
    bif.mar_addr_load_n = 1'b0;
    bif.ram_load_n      = 1'b0;
    tick();
    cpu_idle();
    n_vec++;
    if (bif.mar_out !== 4'hB) begin
      n_err++;
      $display("FAIL lma_wr_mar got=%h exp=b", bif.mar_out);
    end
    read_addr(4'd4, d, oe);
    n_vec++;
    if (d !== 8'h0B) begin
      n_err++;
      $display("FAIL wr_old_mar got=%h exp=0b", d);
    end
    read_addr(4'd11, d, oe);
    n_vec++;
    if (d !== 8'h1B) begin
      n_err++;
      $display("FAIL wr_new_mar_untouched got=%h exp=1b", d);
    end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    logic       oe;
    set_mar(8'h03);
    write_byte(8'h55);
    n_vec++;
    if (bif.conflict_err !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_pre got=%b exp=0", bif.conflict_err);
    end
    bif.bus_in     = 8'hEE;
    bif.ram_en_n   = 1'b0;
    bif.ram_load_n = 1'b0;
    #1;
    n_vec++;
    if (bif.bus_out !== 8'h55 || bif.bus_oe !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_read got out=%h oe=%b exp out=55 oe=1", bif.bus_out, bif.bus_oe);
    end
    tick();
    cpu_idle();
    n_vec++;
    if (bif.conflict_err !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_set got=%b exp=1", bif.conflict_err);
    end
    read_addr(4'd3, d, oe);
    n_vec++;
    if (d !== 8'h55) begin
      n_err++;
      $display("FAIL conflict_nowrite got=%h exp=55", d);
    end
    repeat (10) tick();
    n_vec++;
    if (bif.conflict_err !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_sticky got=%b exp=1", bif.conflict_err);
    end
  endtask

  task automatic test_reload_and_reset();
    logic [7:0] d;
    logic       oe;
    logic [7:0] exp_w [16];
    exp_w = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h16, 8'h3C,
              8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
    bif.prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bif.prog_valid = 1'b1;
      bif.prog_data  = 8'hA0 + 8'(i);
      tick();
    end
    bif.prog_valid = 1'b0;
    n_vec++;
    if (bif.prog_count !== 5'd6) begin
      n_err++;
      $display("FAIL partial_cnt got=%0d exp=6", bif.prog_count);
    end
    bif.prog_mode = 1'b0;
    tick();
    bif.prog_mode = 1'b1;
    tick();
    n_vec++;
    if (bif.prog_count !== 5'd0 || bif.prog_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reenter got cnt=%0d rdy=%b exp cnt=0 rdy=1", bif.prog_count, bif.prog_ready);
    end
    bif.prog_mode = 1'b0;
    tick();
    for (int i = 3; i < 16; i++) begin
      read_addr(4'(i), d, oe);
      n_vec++;
      if (d !== exp_w[i]) begin
        n_err++;
        $display("FAIL partial_ram[%0d] got=%h exp=%h", i, d, exp_w[i]);
      end
    end
    // reset in the middle of a load handshake
    bif.prog_mode = 1'b1;
    tick();
    bif.prog_valid = 1'b1;
    bif.prog_data  = 8'h77;
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (bif.prog_ready !== 1'b0 || bif.prog_count !== 5'd0 || bif.prog_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got rdy=%b cnt=%0d done=%b exp rdy=0 cnt=0 done=0",
               bif.prog_ready, bif.prog_count, bif.prog_done);
    end
    bif.prog_valid = 1'b0;
    bif.prog_mode  = 1'b0;
    rst_n          = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      read_addr(4'(i), d, oe);
      n_vec++;
      if (d !== 8'h00) begin
        n_err++;
        $display("FAIL mid_reset_ram[%0d] got=%h exp=00", i, d);
      end
    end
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    bif.prog_mode  = 1'b0;
    bif.prog_valid = 1'b0;
    bif.prog_data  = 8'h00;
    cpu_idle();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_load();
    test_cpu_rw();
    test_mem_load();
    test_conflict();
    test_reload_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
